tff_count_ctrl: RTL and testbench

TFF_COUNT_CTRL -- requirements
Module: tff_count_ctrl

---
 rtl/tff_count_ctrl.sv | 143 ++++++++++++++
 tb/tb_tff_count_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/tff_count_ctrl.sv
// Sequencer for an external mod-8 counter: loads a preset, counts matches
// against a target, checks the count sequence and tracks 7->0 wraps.
module tff_count_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [2:0] preset,
  input  logic [2:0] target,
  input  logic [3:0] hits,
  input  logic [2:0] q,
  output logic       load,
  output logic [2:0] p,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] wrap_cnt
);

  localparam int unsigned CW = 3;
  localparam int unsigned HW = 4;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t        state, state_d;
  logic [CW-1:0] target_r, target_d;
  logic [CW-1:0] prev_q, prev_q_d;
  logic [CW-1:0] p_d;
  logic [HW-1:0] hits_r, hits_d;
  logic [HW-1:0] match_cnt, match_d;
  logic [HW-1:0] wrap_d;
  logic          first_run, first_d;
  logic          load_d, busy_d, done_d, err_d;
  logic          seq_bad, is_match, is_wrap;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      target_r  <= '0;
      hits_r    <= '0;
      prev_q    <= '0;
      match_cnt <= '0;
      first_run <= 1'b0;
      load      <= 1'b0;
      p         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      wrap_cnt  <= '0;
    end else begin
      state     <= state_d;
      target_r  <= target_d;
      hits_r    <= hits_d;
      prev_q    <= prev_q_d;
      match_cnt <= match_d;
      first_run <= first_d;
      load      <= load_d;
      p         <= p_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
      wrap_cnt  <= wrap_d;
    end
  end

  // Next state; outputs are decoded for the state being entered
  always_comb begin
    state_d  = state;
    target_d = target_r;
    hits_d   = hits_r;
    prev_q_d = prev_q;
    match_d  = match_cnt;
    first_d  = first_run;
    p_d      = p;
    wrap_d   = wrap_cnt;
    err_d    = err;
    load_d   = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    // The first RUN cycle has no predecessor, so sequence and wrap checks skip it
    seq_bad  = !first_run && (q != CW'(prev_q + CW'(1)));
    is_match = (q == target_r);
    is_wrap  = !first_run && (prev_q == CW'(7)) && (q == '0);

    unique case (state)
      IDLE: begin
        if (start) begin
          target_d = target;
          hits_d   = hits;
          p_d      = preset;
          err_d    = 1'b0;
          wrap_d   = '0;
          match_d  = '0;
          state_d  = LOAD;
          load_d   = 1'b1;
          busy_d   = 1'b1;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          state_d = RUN;
          busy_d  = 1'b1;
          first_d = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          busy_d   = 1'b1;
          first_d  = 1'b0;
          prev_q_d = q;
          if (is_wrap && (wrap_cnt != HW'(15))) wrap_d = HW'(wrap_cnt + HW'(1));
          if (seq_bad) begin
            err_d   = 1'b1;
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (is_match) begin
            match_d = HW'(match_cnt + HW'(1));
            // This match is number hits+1 when the count so far equals hits
            if (match_cnt == hits_r) begin
              state_d = DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Directed bench for tff_count_ctrl with a behavioural mod-8 counter and a
// scoreboard of expected run outcomes.
module tb_tff_count_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort;
  logic [2:0] preset, target, q;
  logic [3:0] hits;
  logic       load, busy, done, err;
  logic [2:0] p;
  logic [3:0] wrap_cnt;
  logic       skip_en;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         cycles;
    logic [3:0] wrap;
    logic       err;
  } exp_t;

  exp_t sb[$];

  tff_count_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .preset(preset), .target(target), .hits(hits), .q(q),
    .load(load), .p(p), .busy(busy), .done(done), .err(err),
    .wrap_cnt(wrap_cnt)
  );

  always #5 clk = ~clk;

  // External counter; skip_en forces a 4->6 jump
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 q <= 3'd0;
    else if (load)              q <= p;
    else if (skip_en && q == 3'd4) q <= 3'd6;
    else                        q <= 3'(q + 3'd1);
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_load"}, 16'(load), 16'd0);
    check({pfx, "_p"}, 16'(p), 16'd0);
    check({pfx, "_busy"}, 16'(busy), 16'd0);
    check({pfx, "_done"}, 16'(done), 16'd0);
    check({pfx, "_err"}, 16'(err), 16'd0);
    check({pfx, "_wrap"}, 16'(wrap_cnt), 16'd0);
  endtask

  // Pulse start for one cycle; leaves the caller at the negedge after the LOAD cycle
  task automatic pulse_start(input logic [2:0] pr, input logic [2:0] tg,
                             input logic [3:0] ht, input logic ab);
    @(negedge clk);
    start = 1'b1; abort = ab; preset = pr; target = tg; hits = ht;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("load_pulse", 16'(load), 16'd1);
    check("load_p", 16'(p), 16'(pr));
    check("busy_load", 16'(busy), 16'd1);
    check("err_clr", 16'(err), 16'd0);
    check("wrap_clr", 16'(wrap_cnt), 16'd0);
  endtask

  // Full run: n RUN cycles, then a done pulse carrying wrap count w and err e
  task automatic run(input logic [2:0] pr, input logic [2:0] tg, input logic [3:0] ht,
                     input logic ab, input int n, input logic [3:0] w, input logic e);
    exp_t x;
    int   cnt;
    sb.push_back('{n + 1, w, e});
    pulse_start(pr, tg, ht, ab);
    @(negedge clk);
    check("load_low", 16'(load), 16'd0);
    cnt = 1;
    while (!done && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    x = sb.pop_front();
    check("done_seen", 16'(done), 16'd1);
    check("latency", 16'(cnt), 16'(x.cycles));
    check("wrap", 16'(wrap_cnt), 16'(x.wrap));
    check("err", 16'(err), 16'(x.err));
    check("busy_done", 16'(busy), 16'd0);
    @(negedge clk);
    check("done_1cyc", 16'(done), 16'd0);
    check("wrap_hold", 16'(wrap_cnt), 16'(x.wrap));
  endtask

  initial begin
    logic saw;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; skip_en = 1'b0;
    preset = '0; target = '0; hits = '0;
    #12;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run(3'd5, 3'd2, 4'd0, 1'b0, 6, 4'd1, 1'b0);
    run(3'd3, 3'd3, 4'd1, 1'b0, 9, 4'd1, 1'b0);
    run(3'd0, 3'd7, 4'd15, 1'b0, 128, 4'd15, 1'b0);

    skip_en = 1'b1;
    run(3'd1, 3'd7, 4'd0, 1'b0, 5, 4'd0, 1'b1);
    skip_en = 1'b0;
    repeat (3) @(negedge clk);
    check("err_sticky", 16'(err), 16'd1);

    // start with abort in IDLE still starts; also clears err
    run(3'd6, 3'd1, 4'd0, 1'b1, 4, 4'd1, 1'b0);

    // abort in third RUN cycle, stray start in the first RUN cycle
    pulse_start(3'd2, 3'd1, 4'd0, 1'b0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_ignored", 16'(load), 16'd0);
    check("busy_run", 16'(busy), 16'd1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 16'(busy), 16'd0);
    check("abort_done", 16'(done), 16'd0);
    check("abort_load", 16'(load), 16'd0);
    saw = 1'b0;
    repeat (12) begin
      @(negedge clk);
      saw = saw | done | busy;
    end
    check("abort_quiet", 16'(saw), 16'd0);

    // abort beats a match in the first RUN cycle
    pulse_start(3'd4, 3'd4, 4'd0, 1'b0);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_prio_done", 16'(done), 16'd0);
    check("abort_prio_busy", 16'(busy), 16'd0);

    // asynchronous reset mid-run
    pulse_start(3'd1, 3'd7, 4'd15, 1'b0);
    repeat (12) @(negedge clk);
    check("pre_rst_wrap", 16'(wrap_cnt), 16'd1);
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (10) begin
      @(negedge clk);
      saw = saw | busy | load | done;
    end
    check("no_resume", 16'(saw), 16'd0);

    run(3'd5, 3'd2, 4'd0, 1'b0, 6, 4'd1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
